// File: rtl/srio_target_ram_if.sv
// SRIO logical-layer target streams: treq (core -> target) and tresp (target -> core).
// Latency: none, wiring only.
// Backpressure: AXI-Stream valid/ready on both directions.
interface srio_target_ram_if;
    logic        s_axis_treq_tvalid;
    logic        s_axis_treq_tready;
    logic        s_axis_treq_tlast;
    logic [63:0] s_axis_treq_tdata;
    logic [7:0]  s_axis_treq_tkeep;
    logic [31:0] s_axis_treq_tuser;

    logic        m_axis_tresp_tvalid;
    logic        m_axis_tresp_tready;
    logic        m_axis_tresp_tlast;
    logic [63:0] m_axis_tresp_tdata;
    logic [7:0]  m_axis_tresp_tkeep;
    logic [31:0] m_axis_tresp_tuser;

    // SRIO core side: sources requests, sinks responses
    modport master (
        output s_axis_treq_tvalid, s_axis_treq_tlast, s_axis_treq_tdata,
               s_axis_treq_tkeep, s_axis_treq_tuser,
        input  s_axis_treq_tready,
        input  m_axis_tresp_tvalid, m_axis_tresp_tlast, m_axis_tresp_tdata,
               m_axis_tresp_tkeep, m_axis_tresp_tuser,
        output m_axis_tresp_tready
    );

    // Target side: sinks requests, sources responses
    modport slave (
        input  s_axis_treq_tvalid, s_axis_treq_tlast, s_axis_treq_tdata,
               s_axis_treq_tkeep, s_axis_treq_tuser,
        output s_axis_treq_tready,
        output m_axis_tresp_tvalid, m_axis_tresp_tlast, m_axis_tresp_tdata,
               m_axis_tresp_tkeep, m_axis_tresp_tuser,
        input  m_axis_tresp_tready
    );
endinterface

// File: rtl/srio_target_ram.sv
// SRIO target backed by a local 64-bit RAM: NWRITE/NWRITE_R/SWRITE/NREAD, others dropped and counted.
// Latency: response header valid 1 cycle after the triggering tlast (NWRITE_R) or header (NREAD).
// Backpressure: treq stalled while a response is in flight; tresp outputs held stable until accepted.
module srio_target_ram #(
    parameter int P_ADDR_WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    srio_target_ram_if.slave    bus,
    output logic [15:0]         o_err_cnt
);
    localparam int DEPTH = 1 << P_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, WR_DATA, RD_HDR, RD_DATA, RESP_HDR, DROP} state_t;

    state_t                  state, state_nxt;
    logic [63:0]             mem [DEPTH];
    logic                    rdy_en;      // keeps treq_tready low until the first cycle out of reset
    logic [P_ADDR_WIDTH-1:0] wr_idx, rd_idx;
    logic [4:0]              rd_rem;      // read beats still to be loaded after the current one
    logic                    is_nwr_r;
    logic [63:0]             resp_hdr_r;  // NWRITE_R response, sent once the payload ends
    logic [63:0]             tdata_r;
    logic                    tlast_r;
    logic [31:0]             tuser_r;
    logic                    treq_rdy, resp_vld;

    // Header decode on the live request beat; only meaningful when a header is accepted in IDLE
    logic [63:0] req;
    logic [3:0]  ftype, ttype;
    logic [1:0]  prio, prio_up;
    logic        hdr_wr, hdr_nwr_r, hdr_rd;
    logic [63:0] hdr_resp;
    logic        treq_hs, tresp_hs;
    logic        unused_keep;

    assign req       = bus.s_axis_treq_tdata;
    assign ftype     = req[55:52];
    assign ttype     = req[51:48];
    assign prio      = req[46:45];
    assign prio_up   = (prio == 2'd3) ? 2'd3 : prio + 2'd1;
    assign hdr_wr    = (ftype == 4'd5 && (ttype == 4'd4 || ttype == 4'd5)) || ftype == 4'd6;
    assign hdr_nwr_r = (ftype == 4'd5 && ttype == 4'd5);
    assign hdr_rd    = (ftype == 4'd2 && ttype == 4'd4);
    assign hdr_resp  = {req[63:56], 4'hD, (hdr_rd ? 4'h8 : 4'h0), 1'b0, prio_up, req[44], 44'h0};
    assign treq_hs   = bus.s_axis_treq_tvalid & treq_rdy;
    assign tresp_hs  = resp_vld & bus.m_axis_tresp_tready;
    assign unused_keep = ^bus.s_axis_treq_tkeep;

    assign bus.s_axis_treq_tready  = treq_rdy;
    assign bus.m_axis_tresp_tvalid = resp_vld;
    assign bus.m_axis_tresp_tdata  = tdata_r;
    assign bus.m_axis_tresp_tlast  = tlast_r;
    assign bus.m_axis_tresp_tuser  = tuser_r;
    assign bus.m_axis_tresp_tkeep  = 8'hFF;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and stream handshake outputs
    always_comb begin
        state_nxt = state;
        treq_rdy  = 1'b0;
        resp_vld  = 1'b0;
        case (state)
            IDLE: begin
                treq_rdy = rdy_en;
                if (treq_hs) begin
                    if (hdr_wr)                          state_nxt = WR_DATA;
                    else if (hdr_rd)                     state_nxt = RD_HDR;
                    else if (!bus.s_axis_treq_tlast)     state_nxt = DROP;
                end
            end
            WR_DATA: begin
                treq_rdy = 1'b1;
                if (treq_hs && bus.s_axis_treq_tlast) state_nxt = is_nwr_r ? RESP_HDR : IDLE;
            end
            DROP: begin
                treq_rdy = 1'b1;
                if (treq_hs && bus.s_axis_treq_tlast) state_nxt = IDLE;
            end
            RD_HDR: begin
                resp_vld = 1'b1;
                if (bus.m_axis_tresp_tready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                resp_vld = 1'b1;
                if (bus.m_axis_tresp_tready && tlast_r) state_nxt = IDLE;
            end
            RESP_HDR: begin
                resp_vld = 1'b1;
                if (bus.m_axis_tresp_tready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, response beat loading and drop counting
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdy_en     <= 1'b0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            rd_rem     <= '0;
            is_nwr_r   <= 1'b0;
            resp_hdr_r <= '0;
            tdata_r    <= '0;
            tlast_r    <= 1'b0;
            tuser_r    <= '0;
            o_err_cnt  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (state == IDLE && treq_hs) begin
                wr_idx   <= req[P_ADDR_WIDTH+2:3];
                rd_idx   <= req[P_ADDR_WIDTH+2:3];
                rd_rem   <= req[43:39];
                is_nwr_r <= hdr_nwr_r;
                tuser_r  <= {bus.s_axis_treq_tuser[15:0], bus.s_axis_treq_tuser[31:16]};
                if (hdr_rd) begin
                    tdata_r <= hdr_resp;
                    tlast_r <= 1'b0;
                end else begin
                    resp_hdr_r <= hdr_resp;
                end
                if (!hdr_wr && !hdr_rd && o_err_cnt != 16'hFFFF)
                    o_err_cnt <= o_err_cnt + 16'd1;
            end
            if (state == WR_DATA && treq_hs) begin
                wr_idx <= wr_idx + 1'b1;
                if (bus.s_axis_treq_tlast && is_nwr_r) begin
                    tdata_r <= resp_hdr_r;
                    tlast_r <= 1'b1;
                end
            end
            if (state == RD_HDR && tresp_hs) begin
                tdata_r <= mem[rd_idx];
                rd_idx  <= rd_idx + 1'b1;
                tlast_r <= (rd_rem == 5'd0);
            end
            if (state == RD_DATA && tresp_hs && !tlast_r) begin
                tdata_r <= mem[rd_idx];
                rd_idx  <= rd_idx + 1'b1;
                rd_rem  <= rd_rem - 5'd1;
                tlast_r <= (rd_rem == 5'd1);
            end
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge i_clk) begin
        if (state == WR_DATA && treq_hs) mem[wr_idx] <= req;
    end
endmodule

// File: tb/tb_srio_target_ram.sv
// Randomized bench for srio_target_ram against an array/queue reference model.
// Latency: checks response start within 2 cycles; drains bounded by cycle budgets.
// Backpressure: random tresp_tready with stall-stability checks.
module tb_srio_target_ram;
    logic        clk;
    logic        rst;
    logic [15:0] err_cnt;

    srio_target_ram_if bus();

    srio_target_ram #(.P_ADDR_WIDTH(8)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .o_err_cnt (err_cnt)
    );

    typedef struct {
        logic [63:0] dat;
        logic        last;
        logic [31:0] user;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] ref_mem [256];
    logic [63:0] pay [40];
    int          n_total = 0;
    int          n_bad   = 0;
    int          err_exp = 0;
    int          extra   = 0;
    bit          rand_rdy = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_resp(input logic [7:0] tid, input logic [3:0] tt,
                                            input int prio, input logic crf);
        int p;
        p = (prio + 1 > 3) ? 3 : prio + 1;
        return {tid, 4'hD, tt, 1'b0, p[1:0], crf, 44'h0};
    endfunction

    // Response sink: random ready, stall stability, scoreboard against expected beats
    initial begin
        beat_t       e;
        bit          stalled = 0;
        logic [63:0] s_dat;
        logic        s_last;
        logic [31:0] s_user;
        bus.m_axis_tresp_tready = 1'b0;
        forever begin
            @(negedge clk);
            bus.m_axis_tresp_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.m_axis_tresp_tvalid) begin
                chk("treq_rdy_busy", 64'(bus.s_axis_treq_tready), 64'd0);
                if (stalled) begin
                    chk("stall_dat",  bus.m_axis_tresp_tdata, s_dat);
                    chk("stall_last", 64'(bus.m_axis_tresp_tlast), 64'(s_last));
                    chk("stall_user", 64'(bus.m_axis_tresp_tuser), 64'(s_user));
                end
                chk("tkeep", 64'(bus.m_axis_tresp_tkeep), 64'hFF);
                if (bus.m_axis_tresp_tready) begin
                    stalled = 0;
                    if (exp_q.size() == 0) extra++;
                    else begin
                        e = exp_q.pop_front();
                        chk("resp_dat",  bus.m_axis_tresp_tdata, e.dat);
                        chk("resp_last", 64'(bus.m_axis_tresp_tlast), 64'(e.last));
                        chk("resp_user", 64'(bus.m_axis_tresp_tuser), 64'(e.user));
                    end
                end else begin
                    stalled = 1;
                    s_dat  = bus.m_axis_tresp_tdata;
                    s_last = bus.m_axis_tresp_tlast;
                    s_user = bus.m_axis_tresp_tuser;
                end
            end else begin
                if (stalled) chk("vld_hold", 64'(bus.m_axis_tresp_tvalid), 64'd1);
                stalled = 0;
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic last, input logic [31:0] user);
        bit ok = 0;
        bus.s_axis_treq_tvalid = 1'b1;
        bus.s_axis_treq_tdata  = d;
        bus.s_axis_treq_tlast  = last;
        bus.s_axis_treq_tuser  = user;
        bus.s_axis_treq_tkeep  = 8'hFF;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (bus.s_axis_treq_tready) ok = 1;
            @(negedge clk);
        end
        bus.s_axis_treq_tvalid = 1'b0;
        chk("treq_hs", 64'(ok), 64'd1);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) pay[i] = {$urandom, $urandom};
    endtask

    // Model update + expectations, then drive header and npay payload beats from pay[]
    task automatic do_pkt(input logic [3:0] ft, input logic [3:0] tt, input logic [7:0] tid,
                          input int prio, input logic crf, input logic [7:0] size,
                          input logic [33:0] addr, input int npay, input logic [31:0] user);
        logic [63:0] hdr;
        logic [31:0] sw;
        int          idx, beats;
        bit          is_w, is_wr_r, is_rd;
        beat_t       b;
        hdr   = {tid, ft, tt, 1'b0, 2'(prio), crf, size, 2'b00, addr};
        sw    = {user[15:0], user[31:16]};
        idx   = int'(addr[10:3]);
        beats = int'(size[7:3]) + 1;
        is_w    = (ft == 5 && (tt == 4 || tt == 5)) || ft == 6;
        is_wr_r = (ft == 5 && tt == 5);
        is_rd   = (ft == 2 && tt == 4);
        if (is_w) begin
            for (int i = 0; i < npay; i++) ref_mem[(idx + i) % 256] = pay[i];
            if (is_wr_r) begin
                b.dat = mk_resp(tid, 4'h0, prio, crf); b.last = 1; b.user = sw;
                exp_q.push_back(b);
            end
        end else if (is_rd) begin
            b.dat = mk_resp(tid, 4'h8, prio, crf); b.last = 0; b.user = sw;
            exp_q.push_back(b);
            for (int n = 0; n < beats; n++) begin
                b.dat = ref_mem[(idx + n) % 256]; b.last = (n == beats - 1); b.user = sw;
                exp_q.push_back(b);
            end
        end else begin
            err_exp = (err_exp >= 65535) ? 65535 : err_exp + 1;
        end
        send_beat(hdr, npay == 0, user);
        for (int i = 0; i < npay; i++) send_beat(pay[i], i == npay - 1, user);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_latency(input string tag);
        int lat = 0;
        while (!bus.m_axis_tresp_tvalid && lat < 3) begin
            @(negedge clk);
            lat++;
        end
        chk(tag, 64'(lat <= 2), 64'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_treq_rdy"}, 64'(bus.s_axis_treq_tready), 64'd0);
        chk({tag, "_vld"},      64'(bus.m_axis_tresp_tvalid), 64'd0);
        chk({tag, "_last"},     64'(bus.m_axis_tresp_tlast), 64'd0);
        chk({tag, "_dat"},      bus.m_axis_tresp_tdata, 64'd0);
        chk({tag, "_user"},     64'(bus.m_axis_tresp_tuser), 64'd0);
        chk({tag, "_err"},      64'(err_cnt), 64'd0);
    endtask

    initial begin
        logic [3:0]  ft, tt;
        logic [7:0]  size;
        int          kind, beats, npay;
        rst = 1'b1;
        bus.s_axis_treq_tvalid = 1'b0;
        bus.s_axis_treq_tlast  = 1'b0;
        bus.s_axis_treq_tdata  = '0;
        bus.s_axis_treq_tkeep  = 8'hFF;
        bus.s_axis_treq_tuser  = '0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst0");
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", 64'(bus.s_axis_treq_tready), 64'd1);

        // Give every RAM word a known value
        for (int b = 0; b < 8; b++) begin
            fill_rand(32);
            do_pkt(4'd6, 4'($urandom), 8'(b), 0, 1'b0, 8'hF8, 34'(b * 256), 32, $urandom);
        end
        wait_drain("prefill_drain");

        // NWRITE_R to words 2,3
        pay[0] = 64'hA5A5_0000_0000_0001;
        pay[1] = 64'hA5A5_0000_0000_0002;
        do_pkt(4'd5, 4'd5, 8'h3C, 0, 1'b1, 8'h0F, 34'h10, 2, 32'h1234_5678);
        chk_latency("nwr_r_latency");
        wait_drain("nwr_r_drain");

        // NREAD the same words back
        do_pkt(4'd2, 4'd4, 8'h41, 1, 1'b0, 8'h0F, 34'h10, 0, 32'hAAAA_5555);
        chk_latency("nread_latency");
        wait_drain("nread_drain");
        chk("ram2_model", ref_mem[2], 64'hA5A5_0000_0000_0001);

        // 32-beat read wrapping past the top of the RAM, with random backpressure
        rand_rdy = 1;
        do_pkt(4'd2, 4'd4, 8'h77, 3, 1'b1, 8'hFF, 34'(250 * 8), 0, 32'hDEAD_BEEF);
        wait_drain("wrap_drain");
        rand_rdy = 0;

        // Unsupported 3-beat packet, then a normal NWRITE and read-back
        fill_rand(2);
        do_pkt(4'd8, 4'd0, 8'h01, 0, 1'b0, 8'h10, 34'h200, 2, 32'h0102_0304);
        repeat (2) @(negedge clk);
        chk("err_after_drop", 64'(err_cnt), 64'(err_exp));
        chk("err_is_one", 64'(err_cnt), 64'd1);
        fill_rand(2);
        do_pkt(4'd5, 4'd4, 8'h02, 2, 1'b0, 8'h0F, 34'h100, 2, 32'h1111_2222);
        do_pkt(4'd2, 4'd4, 8'h03, 2, 1'b0, 8'h0F, 34'h100, 0, 32'h3333_4444);
        wait_drain("drop_follow_drain");

        // Random traffic mix
        for (int k = 0; k < 40; k++) begin
            kind  = $urandom_range(0, 5);
            size  = 8'($urandom);
            beats = int'(size[7:3]) + 1;
            tt    = 4'($urandom);
            case (kind)
                0: begin ft = 4'd5; tt = 4'd4; end
                1: begin ft = 4'd5; tt = 4'd5; end
                2: ft = 4'd6;
                3: begin ft = 4'd2; tt = 4'd4; end
                default: begin
                    ft = 4'($urandom);
                    if (ft == 4'd2 || ft == 4'd5 || ft == 4'd6) ft = 4'd9;
                end
            endcase
            if (kind <= 2)      npay = $urandom_range(1, beats + 2);
            else if (kind == 4) npay = $urandom_range(1, 4);
            else                npay = 0;
            fill_rand(npay);
            rand_rdy = bit'($urandom_range(0, 1));
            do_pkt(ft, tt, 8'($urandom), $urandom_range(0, 3), 1'($urandom), size,
                   {2'($urandom), $urandom}, npay, $urandom);
        end
        wait_drain("rand_drain");
        rand_rdy = 0;
        chk("err_after_rand", 64'(err_cnt), 64'(err_exp));

        // Reset in the middle of an NWRITE_R payload
        pay[0] = 64'h0BAD_F00D_1234_5678;
        send_beat({8'h55, 4'd5, 4'd5, 1'b0, 2'd0, 1'b0, 8'h0F, 2'b00, 34'h40}, 1'b0, 32'h5A5A_A5A5);
        send_beat(pay[0], 1'b0, 32'h5A5A_A5A5);
        ref_mem[8] = pay[0];
        rst = 1'b1;
        #1;
        chk_reset_outs("rst_mid");
        repeat (2) @(negedge clk);
        chk_reset_outs("rst_hold");
        err_exp = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst2", 64'(bus.s_axis_treq_tready), 64'd1);
        repeat (3) @(negedge clk);
        chk("no_resp_after_rst", 64'(bus.m_axis_tresp_tvalid), 64'd0);
        do_pkt(4'd2, 4'd4, 8'h60, 0, 1'b0, 8'h0F, 34'h40, 0, 32'h0000_FFFF);
        fill_rand(2);
        do_pkt(4'd5, 4'd5, 8'h61, 2, 1'b1, 8'h0F, 34'h48, 2, 32'hCAFE_0001);
        wait_drain("post_rst_drain");
        chk("err_post_rst", 64'(err_cnt), 64'(err_exp));

        chk("extra_beats", 64'(extra), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/srio_target_ram.md
SRIO_TARGET_RAM -- requirements
Module: srio_target_ram

Interface
REQ-001 P_ADDR_WIDTH, 8, word-address width of the local 64-bit RAM; depth = 2^P_ADDR_WIDTH words.
REQ-002 i_clk  input  1  logical-layer clock (log_clk of the SRIO core port); sole clock.
REQ-003 i_rst  input  1  reset; asynchronous, active-high.
REQ-004 s_axis_treq_tvalid/tready/tlast  in/out/in  1 each  target request stream from SRIO core, HELLO format.
REQ-005 s_axis_treq_tdata  input  64  header beat or payload beat.
REQ-006 s_axis_treq_tkeep  input  8  byte enables; ignored, full 8-byte beats only.
REQ-007 s_axis_treq_tuser  input  32  [31:16] source ID, [15:0] destination ID.
REQ-008 m_axis_tresp_tvalid/tready/tlast  out/in/out  1 each  target response stream to SRIO core.
REQ-009 m_axis_tresp_tdata  output  64  response header or read data.
REQ-010 m_axis_tresp_tkeep  output  8  constant 8'hFF.
REQ-011 m_axis_tresp_tuser  output  32  request tuser with halves swapped: {req[15:0], req[31:16]}.
REQ-012 o_err_cnt  output  16  count of dropped (unsupported) requests, saturating at 16'hFFFF.

Function
REQ-013 Header fields: TID[63:56], FTYPE[55:52], TTYPE[51:48], PRIO[46:45], CRF[44], SIZE[43:36], ADDR[33:0]; beats = SIZE[7:3]+1 (1..32).
REQ-014 RAM word index = ADDR[P_ADDR_WIDTH+2:3] + beat index, modulo 2^P_ADDR_WIDTH (wrap-around, no error).
REQ-015 Supported: NWRITE (FTYPE 5, TTYPE 4), NWRITE_R (5/5), SWRITE (FTYPE 6, any TTYPE), NREAD (FTYPE 2, TTYPE 4); all others unsupported.
REQ-016 FSM states: IDLE, WR_DATA, RD_HDR, RD_DATA, RESP_HDR, DROP.
REQ-017 IDLE: tready=1; on accepted header beat -> WR_DATA (write types), RD_HDR (NREAD), DROP (unsupported and tlast=0); unsupported with tlast=1 stays IDLE.
REQ-018 WR_DATA: tready=1; each accepted beat writes full 64 bits to RAM; on tlast -> RESP_HDR if NWRITE_R else IDLE.
REQ-019 Payload beats beyond SIZE-implied count are written (index keeps incrementing); tlast alone terminates the packet.
REQ-020 DROP: tready=1, beats discarded; on tlast -> IDLE; o_err_cnt increments once per dropped packet, at header acceptance.
REQ-021 RD_HDR, RD_DATA, RESP_HDR: s_axis_treq_tready=0.
REQ-022 Response header: TID=req TID, FTYPE=4'hD, TTYPE=8 (with data, NREAD) or 0 (NWRITE_R), PRIO=min(req PRIO+1,3), CRF=req CRF, all other bits 0.
REQ-023 RESP_HDR: header beat with tlast=1; on handshake -> IDLE.
REQ-024 RD_HDR: header beat tlast=0; on handshake -> RD_DATA.
REQ-025 RD_DATA: beat n carries RAM[start+n], n=0..beats-1; tlast=1 on final beat; on final handshake -> IDLE.
REQ-026 tresp tdata/tlast/tuser SHALL hold stable while tvalid=1 and tready=0 (AXIS rule); tvalid never drops before handshake.
REQ-027 Latency: first tresp tvalid no later than 2 cycles after accepting the triggering tlast (NWRITE_R) or header (NREAD).
REQ-028 Sustained read throughput: one beat per cycle while tready=1.
REQ-029 Write followed immediately by NREAD to same address returns the newly written data.

Reset
REQ-030 On i_rst high: FSM=IDLE, treq_tready=0, tresp_tvalid=0, tlast=0, tdata=0, tuser=0, o_err_cnt=0; RAM contents not cleared.
REQ-031 treq_tready rises the first cycle after i_rst deasserts; reset mid-packet abandons the packet with no response.

Verification
REQ-032 NWRITE_R, ADDR=0x10, SIZE=0x0F, data 0xA5A5_0000_0000_0001/…0002 -> RAM[2],RAM[3] written; one tresp beat, FTYPE D, TTYPE 0, tlast=1, tuser swapped.
REQ-033 Then NREAD ADDR=0x10, SIZE=0x0F, PRIO=1 -> header (TTYPE 8, PRIO 2) then 2 data beats equal to written values, tlast on beat 2.
REQ-034 NREAD SIZE=0xFF with ADDR=word 250 (P_ADDR_WIDTH=8) -> 32 data beats, indices 250..255 then 0..25 (wrap).
REQ-035 Randomised tresp_tready (50%) during 32-beat read -> data/tlast stable when stalled, no beat lost or duplicated; treq_tready=0 throughout.
REQ-036 Unsupported FTYPE 8, 3-beat packet -> all beats accepted, no tresp, o_err_cnt 0->1; following NWRITE processed normally.
REQ-037 i_rst pulsed during WR_DATA -> all outputs at reset values, o_err_cnt=0, no response; next NWRITE_R answered normally.
